// File: rtl/tick_counter_pkg.sv
// tick_counter_pkg: shared types and prescaler sizing helpers for the tick counter bank.
package tick_counter_pkg;

    typedef enum logic [1:0] {WRAP = 2'd0, SAT = 2'd1, ONESHOT = 2'd2} mode_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} chan_state_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int presc_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider emitting a one-cycle tick every CLK_HZ/TICK_HZ cycles.
module tick_prescaler
    import tick_counter_pkg::*;
#(
    parameter int CLK_HZ  = 84000000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int W   = presc_w(DIV);

    if (DIV < 2) begin : g_div_chk
        $error("tick_prescaler: CLK_HZ/TICK_HZ must be >= 2");
    end

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = cnt == W'(DIV - 1);

    // tick is registered, so it is high in the cycle after the counter sits at DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            tick <= wrap;
        end
    end
endmodule

// File: rtl/tick_counter_bank.sv
// tick_counter_bank: NUM_CH tick-driven counters (wrap/saturate/one-shot) with coherent snapshot.
module tick_counter_bank
    import tick_counter_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int CLK_HZ  = 84000000,
    parameter int TICK_HZ = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [CNT_W-1:0]        limit,
    input  logic                    snap_req,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH-1:0]       done,
    output logic                    tick,
    output logic [NUM_CH*CNT_W-1:0] snap_count,
    output logic                    snap_valid
);
    if (NUM_CH < 1 || NUM_CH > 32 || CNT_W < 8 || CNT_W > 64) begin : g_param_chk
        $error("tick_counter_bank: NUM_CH must be 1..32 and CNT_W 8..64");
    end

    logic [NUM_CH-1:0] prev_enable;
    logic [NUM_CH-1:0] rise;

    assign rise = enable & ~prev_enable;

    tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // snapshot takes the bus as it stands in the request cycle, before this edge's updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_enable <= '0;
            snap_count  <= '0;
            snap_valid  <= 1'b0;
        end else begin
            prev_enable <= enable;
            snap_valid  <= snap_req;
            if (snap_req) snap_count <= count;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_state_t      state;
        mode_t            ch_mode;
        mode_t            req_mode;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] nxt;
        logic             ch_ovf;
        logic             ch_done;
        assign nxt      = cnt + 1'b1;
        assign req_mode = (mode[2*i +: 2] == 2'(SAT))     ? SAT :
                          (mode[2*i +: 2] == 2'(ONESHOT)) ? ONESHOT : WRAP;
        // clear on a rising edge takes priority over a coincident tick
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= IDLE;
                ch_mode <= WRAP;
                cnt     <= '0;
                ch_ovf  <= 1'b0;
                ch_done <= 1'b0;
            end else if (!enable[i]) begin
                state <= IDLE;
            end else if (rise[i]) begin
                state   <= RUN;
                ch_mode <= req_mode;
                cnt     <= '0;
                ch_ovf  <= 1'b0;
                ch_done <= 1'b0;
            end else if (state == RUN && tick) begin
                if (ch_mode == ONESHOT && (limit == '0 || nxt == limit)) begin
                    cnt     <= limit;
                    ch_done <= 1'b1;
                    state   <= DONE;
                end else if (ch_mode == SAT && &cnt) begin
                    ch_ovf <= 1'b1;
                end else begin
                    cnt <= nxt;
                    if (ch_mode == WRAP && &cnt) ch_ovf <= 1'b1;
                end
            end
        end
        assign count[i*CNT_W +: CNT_W] = cnt;
        assign ovf[i]                  = ch_ovf;
        assign done[i]                 = ch_done;
    end
endmodule

// File: tb/tb_tick_counter_bank.sv
// tb_tick_counter_bank: scoreboard bench comparing the counter bank against a cycle-level reference model.
module tb_tick_counter_bank;
    localparam int N       = 2;
    localparam int W       = 8;
    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAXV    = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   enable = '0;
    logic [2*N-1:0] mode = '0;
    logic [W-1:0]   limit = '0;
    logic           snap_req = 1'b0;
    logic [N*W-1:0] count;
    logic [N-1:0]   ovf;
    logic [N-1:0]   done;
    logic           tick;
    logic [N*W-1:0] snap_count;
    logic           snap_valid;

    tick_counter_bank #(.NUM_CH(N), .CNT_W(W), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .limit      (limit),
        .snap_req   (snap_req),
        .count      (count),
        .ovf        (ovf),
        .done       (done),
        .tick       (tick),
        .snap_count (snap_count),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0] cnt;
        logic [N-1:0]   ovf;
        logic [N-1:0]   done;
        logic           tick;
        logic           sv;
    } obs_t;

    obs_t           exp_q[$];
    logic [N*W-1:0] snap_q[$];
    int             tests = 0;
    int             fails = 0;

    // reference model: edges since reset release, per-channel value/flags/running
    int m_cnt[N];
    bit m_ovf[N];
    bit m_done[N];
    bit m_run[N];
    int m_mode[N];
    bit m_pen[N];
    int cyc;

    function automatic bit tick_now();
        return cyc > 0 && cyc % DIV == 0;
    endfunction

    function automatic logic [N*W-1:0] model_counts();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_cnt[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_done[i] = 0; m_run[i] = 0; m_mode[i] = 0; m_pen[i] = 0;
        end
        cyc = 0;
    endtask

    task automatic step();
        bit             t;
        bit             sreq;
        logic [N*W-1:0] snap_v;
        obs_t           e;
        t      = tick_now();
        sreq   = snap_req;
        snap_v = model_counts();
        for (int i = 0; i < N; i++) begin
            if (!enable[i]) begin
                m_run[i] = 0;
            end else if (!m_pen[i]) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_done[i] = 0; m_run[i] = 1;
                m_mode[i] = int'(mode[2*i +: 2]);
            end else if (m_run[i] && t) begin
                if (m_mode[i] == 2) begin
                    if (limit == 0 || m_cnt[i] + 1 == int'(limit)) begin
                        m_cnt[i] = int'(limit); m_done[i] = 1; m_run[i] = 0;
                    end else begin
                        m_cnt[i] = (m_cnt[i] + 1) % (MAXV + 1);
                    end
                end else if (m_mode[i] == 1) begin
                    if (m_cnt[i] == MAXV) m_ovf[i] = 1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    if (m_cnt[i] == MAXV) begin m_cnt[i] = 0; m_ovf[i] = 1; end
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_pen[i] = enable[i];
        end
        cyc++;
        e.cnt  = model_counts();
        for (int i = 0; i < N; i++) begin e.ovf[i] = m_ovf[i]; e.done[i] = m_done[i]; end
        e.tick = (cyc % DIV == 0);
        e.sv   = sreq;
        @(posedge clk);
        exp_q.push_back(e);
        if (sreq) snap_q.push_back(snap_v);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        if (check) begin
            tests++;
            if ({count, ovf, done, tick, snap_count, snap_valid} !== '0) begin
                fails++;
                $display("FAIL async_reset: got count=%h ovf=%b done=%b tick=%b snap=%h sv=%b, want all zero",
                         count, ovf, done, tick, snap_count, snap_valid);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        obs_t           a;
        obs_t           e;
        logic [N*W-1:0] s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {count, ovf, done, tick, snap_valid};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL live t=%0t: got cnt=%h ovf=%b done=%b tick=%b sv=%b, want cnt=%h ovf=%b done=%b tick=%b sv=%b",
                             $time, a.cnt, a.ovf, a.done, a.tick, a.sv, e.cnt, e.ovf, e.done, e.tick, e.sv);
                end
            end
            if (snap_valid === 1'b1) begin
                tests++;
                if (snap_q.size() == 0) begin
                    fails++;
                    $display("FAIL snap_unexpected t=%0t: got snap_valid=1 snap=%h, want no capture", $time, snap_count);
                end else begin
                    s = snap_q.pop_front();
                    if (snap_count !== s) begin
                        fails++;
                        $display("FAIL snap_value t=%0t: got %h, want %h", $time, snap_count, s);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int k;
        model_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        // channel 0 starts at cycle 3 in WRAP, channel 1 idle
        step_n(3);
        enable[0] = 1'b1;
        step_n(55);
        // full wrap with 8-bit counter, then saturation
        enable = '0; step_n(2);
        enable[0] = 1'b1;
        step_n(256 * DIV + 5);
        enable = '0; step();
        mode[1:0] = 2'd1; enable[0] = 1'b1;
        step_n(300 * DIV);
        // one-shot with limit 3, restart, then limit 0
        enable = '0; step();
        mode[1:0] = 2'd2; limit = 8'd3; enable[0] = 1'b1;
        step_n(6 * DIV);
        enable[0] = 1'b0; step();
        enable[0] = 1'b1; step_n(2);
        limit = 8'd0;
        enable[0] = 1'b0; step();
        enable[0] = 1'b1; step_n(2 * DIV);
        // rising edge and falling edge coincident with tick
        enable = '0; mode = '0; step();
        while (!tick_now()) step();
        enable[0] = 1'b1; step();
        step_n(2 * DIV);
        while (!tick_now()) step();
        enable[0] = 1'b0; step();
        step_n(3);
        // snapshot with channels at 7 and 12, coincident with a tick
        enable = '0; step();
        enable[1] = 1'b1;
        while (m_cnt[1] != 5) step();
        step_n(2);
        enable[0] = 1'b1;
        while (!(m_cnt[0] == 7 && tick_now())) step();
        snap_req = 1'b1; step();
        snap_req = 1'b0; step_n(3);
        snap_req = 1'b1; step_n(2);
        snap_req = 1'b0; step_n(2);
        // reset mid-run with enables held high
        enable = '1; mode = 4'b0001;
        step_n(3 * DIV);
        do_reset(1'b1);
        step_n(3 * DIV + 3);
        // randomized traffic
        for (int r = 0; r < 4000; r++) begin
            if ($urandom_range(0, 25) == 0) begin
                k = $urandom_range(0, N - 1);
                enable[k] = ~enable[k];
            end
            if ($urandom_range(0, 40) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 60) == 0) limit = 8'($urandom_range(0, 6));
            snap_req = ($urandom_range(0, 9) == 0);
            step();
        end
        snap_req = 1'b0;
        step_n(2);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0 || snap_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d live and %0d snapshot entries pending, want 0 and 0", exp_q.size(), snap_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tick_counter_bank.md
Name: tick_counter_bank

Overview:
Parametrised multi-channel successor to the single 1 Hz run counter. A shared prescaler derives a one-cycle tick from the fabric clock. NUM_CH independent counters each start on an enable rising edge and count in wrap, saturate or one-shot mode. A snapshot port captures all channels coherently for the PS-side register read.

Parameters:
NUM_CH, 4, number of independent counter channels (1..32)
CNT_W, 32, counter width in bits (8..64)
CLK_HZ, 84000000, input clock frequency
TICK_HZ, 1, tick rate; DIV = CLK_HZ/TICK_HZ, must be >= 2 (elaboration error otherwise)

Ports:
clk  in  1  fabric clock from PS
rst  in  1  reset, asynchronous, active-high
enable  in  NUM_CH  per-channel run control (level)
mode  in  2*NUM_CH  per-channel mode: 0 WRAP, 1 SAT, 2 ONESHOT, 3 reserved (treated as WRAP)
limit  in  CNT_W  one-shot terminal count, shared by all channels
snap_req  in  1  single-cycle snapshot request
count  out  NUM_CH*CNT_W  live counts, channel i at [i*CNT_W +: CNT_W]
ovf  out  NUM_CH  sticky wrap/saturation flag per channel
done  out  NUM_CH  one-shot complete, level, per channel
tick  out  1  prescaler tick, for debug/observation
snap_count  out  NUM_CH*CNT_W  captured counts
snap_valid  out  1  one-cycle pulse when snap_count is updated

Behaviour:
- Reset (async assert, sync release): prescaler=0, tick=0, all count=0, ovf=0, done=0, state=IDLE, prev_enable=0, snap_count=0, snap_valid=0.
- Prescaler: free-running 0..DIV-1 from reset release. tick=1 for exactly one cycle when prescaler wraps DIV-1->0, so period is DIV cycles. First tick occurs DIV cycles after reset release. Independent of enables.
- Edge detect: prev_enable registered every cycle. Rising edge = enable[i] & ~prev_enable[i]. Enable high through reset release counts as a rising edge on the first cycle.
- Per-channel FSM states are IDLE, RUN and DONE.
  - Any state, enable[i]=0: go to IDLE; count, ovf and done hold their values.
  - Rising edge from any state: count<=0, ovf<=0, done<=0, latch mode[i] into channel mode register, go to RUN.
  - RUN on tick, WRAP: count<=count+1 modulo 2^CNT_W. On all-ones->0, set ovf.
  - RUN on tick, SAT: if count is all-ones, hold and set ovf; else increment.
  - RUN on tick, ONESHOT: if count+1==limit, count<=limit, done<=1, go to DONE; else increment. limit==0 means done on the first tick, with count held at 0.
  - DONE: count held and done held until the next rising edge or enable low.
- Simultaneous rising edge and tick: clear wins, count=0, and that tick is not counted.
- Enable falling and tick in the same cycle: enable already 0, so the tick is ignored.
- Mode changes while in RUN have no effect until the next rising edge. limit is sampled live on every tick.
- Snapshot: snap_req sampled at cycle N. snap_count <= count as held at N (pre-update values, all channels the same cycle). snap_valid=1 at N+1 only. Back-to-back requests give back-to-back captures.
- Latency: count updates in the cycle after tick or edge is sampled. done rises in the same cycle that count reaches limit.
- Reset asserted mid-run: all outputs clear immediately (asynchronously).

Decomposition:
- Package tick_counter_pkg holds:
  - mode_t enum (WRAP, SAT, ONESHOT)
  - chan_state_t enum (IDLE, RUN, DONE)
  - function computing DIV and prescaler width as $clog2(DIV)
- Sub-module tick_prescaler (params CLK_HZ, TICK_HZ; ports clk, rst, tick).
- Channels are built with a generate loop inside tick_counter_bank; no further sub-modules.

Test Plan:
- CLK_HZ=10, TICK_HZ=1, NUM_CH=2, WRAP. enable[0] rises at cycle 3 -> count0 goes 0 then increments every 10 cycles; after 5 ticks count0=5, count1 stays 0.
- CNT_W=8, WRAP, run 256 ticks -> count=0 and ovf=1. Then SAT from a fresh rising edge, 300 ticks -> count=255, ovf=1.
- ONESHOT, limit=3 -> after the 3rd tick count=3 and done=1; further ticks leave count=3. Deassert then reassert enable -> count=0, done=0. limit=0 -> done on first tick with count=0.
- Rising edge forced in the same cycle as tick -> count=0 next cycle, first increment at the following tick. Falling edge coincident with tick -> count unchanged.
- Two channels at 7 and 12, snap_req pulse coincident with tick -> snap_count={12,7} (pre-update), snap_valid high for exactly 1 cycle, live counts read 8/13.
- rst asserted mid-count with enable held high -> all outputs 0 immediately. After release, channel restarts from 0 and first tick arrives DIV cycles later.
